// File: rtl/arb_pkg.sv
// Shared types and widths for the four-way round-robin arbiter.
// Imported by the arbiter FSM and its rotate-priority picker.
package arb_pkg;

  localparam int N_REQ  = 4;
  localparam int IDX_W  = 2;
  localparam int HOLD_W = 8;

  typedef enum logic {
    IDLE,
    BUSY
  } arb_state_t;

endpackage

// File: rtl/rr_pick_4.sv
// Rotate-priority picker: first set request at or after ptr, mod 4.
// Purely combinational; feeds the arbiter FSM.
module rr_pick_4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] pick_idx,
  output logic [N_REQ-1:0] pick_oh,
  output logic             any
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   off;

  assign dbl = {req, req} >> ptr;
  assign rot = dbl[N_REQ-1:0];
  assign any = |req;

  // Lowest rotated index wins, so a priority decode is required here.
  always_comb begin
    off = '0;
    priority case (1'b1)
      rot[0]: off = 2'd0;
      rot[1]: off = 2'd1;
      rot[2]: off = 2'd2;
      rot[3]: off = 2'd3;
      default: off = '0;
    endcase
  end

  assign pick_idx = off + ptr;

  always_comb begin
    pick_oh = '0;
    if (any) pick_oh[pick_idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arb_4.sv
// Round-robin arbiter for four requesters with grant hold limit.
// Grants are held until done, owner drop, or forced preemption.
module rr_arb_4
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             preempt
);

  localparam logic [HOLD_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);
  localparam logic LIM_EN = (MAX_HOLD != 0);

  arb_state_t        state_q;
  logic [IDX_W-1:0]  ptr_q;
  logic [HOLD_W-1:0] hold_q;
  logic [N_REQ-1:0]  gnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic              vld_q;
  logic              pre_q;

  logic [IDX_W-1:0]  pick_idx;
  logic [N_REQ-1:0]  pick_oh;
  logic              pick_any;

  logic rel_done;
  logic rel_drop;
  logic rel_lim;
  logic release_d;

  rr_pick_4 u_pick (
    .req      (req),
    .ptr      (ptr_q),
    .pick_idx (pick_idx),
    .pick_oh  (pick_oh),
    .any      (pick_any)
  );

  always_comb begin
    rel_done  = done;
    rel_drop  = ~req[idx_q];
    rel_lim   = LIM_EN && (hold_q == HOLD_LAST);
    release_d = rel_done | rel_drop | rel_lim;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      pre_q   <= 1'b0;
    end else begin
      pre_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pick_any) begin
            state_q <= BUSY;
            gnt_q   <= pick_oh;
            idx_q   <= pick_idx;
            vld_q   <= 1'b1;
            hold_q  <= '0;
          end
        end
        BUSY: begin
          if (release_d) begin
            state_q <= IDLE;
            ptr_q   <= idx_q + 2'd1;
            gnt_q   <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            hold_q  <= '0;
            // Forced end only when nothing else would have released.
            pre_q   <= rel_lim & ~rel_done & ~rel_drop;
          end else if (hold_q != '1) begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = vld_q;
  assign preempt   = pre_q;

endmodule

// File: tb/tb_rr_arb_4.sv
// Randomized scoreboard bench for rr_arb_4 at hold limits 8, 4 and 0.
// Reference model tracks owner, cycles held and next-priority slot.
module tb_rr_arb_4;

  localparam int ND = 3;
  localparam int HL [ND] = '{8, 4, 0};

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       vld;
    logic       pre;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0;
  logic       done = 1'b0;

  logic [3:0] gnt_w [ND];
  logic [1:0] idx_w [ND];
  logic       vld_w [ND];
  logic       pre_w [ND];

  int checks = 0;
  int failures = 0;
  int pre_seen [ND];

  exp_t q [ND][$];

  bit m_busy [ND];
  int m_own  [ND];
  int m_held [ND];
  int m_ptr  [ND];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    rr_arb_4 #(.MAX_HOLD(HL[g])) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .done      (done),
      .gnt       (gnt_w[g]),
      .gnt_idx   (idx_w[g]),
      .gnt_valid (vld_w[g]),
      .preempt   (pre_w[g])
    );
  end

  function automatic exp_t idle_exp(bit pre);
    exp_t e;
    e = '0;
    e.pre = pre;
    return e;
  endfunction

  function automatic exp_t own_exp(int own);
    exp_t e;
    e = '0;
    e.gnt = 4'(1 << own);
    e.idx = 2'(own);
    e.vld = 1'b1;
    return e;
  endfunction

  // Reference model: decides the outputs following each edge.
  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < ND; d++) begin
      if (!rst_n) begin
        m_busy[d] = 0;
        m_own[d]  = 0;
        m_held[d] = 0;
        m_ptr[d]  = 0;
        if (clk) q[d].push_back(idle_exp(0));
        else q[d].delete();
      end else if (!m_busy[d]) begin
        if (req != 0) begin
          for (int k = 0; k < 4; k++) begin
            if (!m_busy[d] && req[(m_ptr[d] + k) % 4]) begin
              m_busy[d] = 1;
              m_own[d]  = (m_ptr[d] + k) % 4;
            end
          end
          m_held[d] = 1;
          q[d].push_back(own_exp(m_own[d]));
        end else begin
          q[d].push_back(idle_exp(0));
        end
      end else begin
        bit rd, rq, rl;
        rd = done;
        rq = !req[m_own[d]];
        rl = (HL[d] != 0) && (m_held[d] >= HL[d]);
        if (rd || rq || rl) begin
          m_busy[d] = 0;
          m_ptr[d]  = (m_own[d] + 1) % 4;
          q[d].push_back(idle_exp(rl && !rd && !rq));
        end else begin
          m_held[d]++;
          q[d].push_back(own_exp(m_own[d]));
        end
      end
    end
  end

  // Monitor: compare DUT outputs mid-cycle against queued expectations.
  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (q[d].size() > 0) begin
        exp_t e;
        exp_t a;
        e = q[d].pop_front();
        a = {gnt_w[d], idx_w[d], vld_w[d], pre_w[d]};
        checks++;
        if (a.pre) pre_seen[d]++;
        if (a !== e) begin
          failures++;
          $display("FAIL out[hold=%0d] t=%0t got gnt=%b idx=%0d vld=%b pre=%b want gnt=%b idx=%0d vld=%b pre=%b",
                   HL[d], $time, a.gnt, a.idx, a.vld, a.pre,
                   e.gnt, e.idx, e.vld, e.pre);
        end
      end
    end
  end

  task automatic drive(input logic [3:0] r, input logic dn, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req  = r;
      done = dn;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      checks++;
      if ({gnt_w[d], idx_w[d], vld_w[d], pre_w[d]} !== 8'b0) begin
        failures++;
        $display("FAIL async_reset[hold=%0d] got gnt=%b idx=%0d vld=%b pre=%b want all zero",
                 HL[d], gnt_w[d], idx_w[d], vld_w[d], pre_w[d]);
      end
    end
    @(negedge clk);
    #3 rst_n = 1'b1;
  endtask

  initial begin
    for (int d = 0; d < ND; d++) pre_seen[d] = 0;
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    drive(4'b0000, 1'b0, 2);
    drive(4'b1111, 1'b0, 1);
    drive(4'b1111, 1'b1, 2);
    drive(4'b0000, 1'b0, 2);
    drive(4'b0010, 1'b0, 3);
    drive(4'b0010, 1'b1, 1);
    drive(4'b0000, 1'b0, 2);
    drive(4'b1111, 1'b1, 1);
    drive(4'b0000, 1'b0, 2);
    drive(4'b1111, 1'b1, 12);
    drive(4'b0000, 1'b0, 2);
    drive(4'b0001, 1'b0, 25);
    drive(4'b0000, 1'b0, 2);
    drive(4'b1000, 1'b0, 5);
    drive(4'b0000, 1'b0, 3);
    drive(4'b0001, 1'b0, 4);
    drive(4'b0001, 1'b1, 1);
    drive(4'b0000, 1'b0, 2);
    drive(4'b0100, 1'b0, 3);
    do_reset();
    drive(4'b1111, 1'b0, 3);
    drive(4'b0000, 1'b0, 2);
    for (int i = 0; i < 600; i++) begin
      logic [3:0] r;
      logic       dn;
      r  = 4'($urandom);
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      dn = ($urandom_range(0, 9) == 0);
      drive(r, dn, $urandom_range(1, 6));
      if ($urandom_range(0, 150) == 0) do_reset();
    end
    drive(4'b0000, 1'b0, 3);
    for (int d = 0; d < ND; d++) begin
      checks++;
      if ((HL[d] != 0) != (pre_seen[d] != 0)) begin
        failures++;
        $display("FAIL preempt_seen[hold=%0d] got %0d pulses want %s",
                 HL[d], pre_seen[d], (HL[d] != 0) ? "some" : "none");
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
